// File: rtl/sb_handshake_engine_pkg.sv
// Shared types for the sideband handshake engine: message field enums,
// engine FSM states and the request-to-response code mapping.
package sb_handshake_engine_pkg;

  localparam int SB_STATE_W = 3;
  localparam int SB_SUB_W   = 4;
  localparam int SB_CODE_W  = 4;

  typedef enum logic [SB_STATE_W-1:0] {
    ST_RESET      = 3'd0,
    ST_SBINIT     = 3'd1,
    ST_MBINIT     = 3'd2,
    ST_MBTRAIN    = 3'd3,
    ST_LINKINIT   = 3'd4,
    ST_ACTIVE     = 3'd5,
    ST_L1         = 3'd6,
    ST_TRAINERROR = 3'd7
  } state_e;

  typedef enum logic [SB_SUB_W-1:0] {
    SUB_PARAM      = 4'd0,
    SUB_CAL        = 4'd1,
    SUB_REPAIRCLK  = 4'd2,
    SUB_REPAIRVAL  = 4'd3,
    SUB_REVERSALMB = 4'd4,
    SUB_REPAIRMB   = 4'd5
  } substate_e;

  // Requests are odd, the paired response is the next code up.
  typedef enum logic [SB_CODE_W-1:0] {
    MSG_NONE       = 4'd0,
    MSG_START_REQ  = 4'd1,
    MSG_START_RESP = 4'd2,
    MSG_DONE_REQ   = 4'd3,
    MSG_DONE_RESP  = 4'd4
  } msg_e;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERROR} hs_fsm_e;

  function automatic logic [31:0] resp_of(input logic [31:0] req);
    return req + 32'd1;
  endfunction

endpackage

// File: rtl/sb_hs_timer.sv
// Handshake watchdog: counts enabled cycles from start, saturates at the
// last count and flags expiry while that count is held.
module sb_hs_timer #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          cnt_q <= '0;
    else if (i_start || i_clear)        cnt_q <= '0;
    else if (i_enable && cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
  end

  assign o_expired = i_enable && (cnt_q == LAST);

endmodule

// File: rtl/sb_handshake_engine.sv
// Sideband request/response handshake engine for LTSM substates.
// Define SB_HS_TIMEOUT_EN to enable the timeout watchdog and ERROR state.
module sb_handshake_engine
  import sb_handshake_engine_pkg::*;
#(
  parameter int STATE_W        = 3,
  parameter int SUB_W          = 4,
  parameter int CODE_W         = 4,
  parameter int TIMEOUT_CYCLES = 8000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [STATE_W-1:0] i_state,
  input  logic [SUB_W-1:0]   i_substate,
  input  logic [CODE_W-1:0]  i_req_code,
  output logic               o_tx_valid,
  output logic [STATE_W-1:0] o_tx_state,
  output logic [SUB_W-1:0]   o_tx_substate,
  output logic [CODE_W-1:0]  o_tx_code,
  input  logic               i_tx_ready,
  input  logic               i_rx_valid,
  input  logic [STATE_W-1:0] i_rx_state,
  input  logic [SUB_W-1:0]   i_rx_substate,
  input  logic [CODE_W-1:0]  i_rx_code,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_unexpected
);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  hs_fsm_e            fsm_q, fsm_n;
  logic [STATE_W-1:0] lat_state_q, lat_state_n, buf_state_q, buf_state_n, tx_state_n;
  logic [SUB_W-1:0]   lat_sub_q, lat_sub_n, buf_sub_q, buf_sub_n, tx_sub_n;
  logic [CODE_W-1:0]  lat_req_q, lat_req_n, buf_code_q, buf_code_n, tx_code_n, resp_q;
  logic req_sent_q, req_sent_n, resp_rcvd_q, resp_rcvd_n;
  logic resp_pend_q, resp_pend_n, resp_sent_q, resp_sent_n;
  logic buf_vld_q, buf_vld_n, tx_valid_n, timeout_n, unexp_n;
  logic rx_hit, early_hit, expired;

  assign resp_q = CODE_W'(resp_of(32'(lat_req_q)));
  assign rx_hit = i_rx_valid && i_rx_state == lat_state_q && i_rx_substate == lat_sub_q;
  // A partner REQ seen before start, either buffered or arriving with the start itself.
  assign early_hit =
    (buf_vld_q && buf_state_q == i_state && buf_sub_q == i_substate && buf_code_q == i_req_code) ||
    (fsm_q == IDLE && i_rx_valid && i_rx_state == i_state && i_rx_substate == i_substate &&
     i_rx_code == i_req_code);

`ifdef SB_HS_TIMEOUT_EN
  sb_hs_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (fsm_q != ACTIVE && fsm_n == ACTIVE),
    .i_clear   (fsm_q != ACTIVE),
    .i_enable  (fsm_q == ACTIVE),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    fsm_n       = fsm_q;
    lat_state_n = lat_state_q;
    lat_sub_n   = lat_sub_q;
    lat_req_n   = lat_req_q;
    req_sent_n  = req_sent_q;
    resp_rcvd_n = resp_rcvd_q;
    resp_pend_n = resp_pend_q;
    resp_sent_n = resp_sent_q;
    buf_vld_n   = buf_vld_q;
    buf_state_n = buf_state_q;
    buf_sub_n   = buf_sub_q;
    buf_code_n  = buf_code_q;
    tx_valid_n  = 1'b0;
    tx_state_n  = o_tx_state;
    tx_sub_n    = o_tx_substate;
    tx_code_n   = o_tx_code;
    timeout_n   = o_timeout;
    unexp_n     = 1'b0;
    case (fsm_q)
      IDLE, ERROR: begin
        if (fsm_q == IDLE && i_rx_valid && i_rx_code[0]) begin
          buf_vld_n   = 1'b1;
          buf_state_n = i_rx_state;
          buf_sub_n   = i_rx_substate;
          buf_code_n  = i_rx_code;
        end
        if (i_start && !i_req_code[0]) begin
          unexp_n = 1'b1;
        end else if (i_start) begin
          fsm_n       = ACTIVE;
          timeout_n   = 1'b0;
          lat_state_n = i_state;
          lat_sub_n   = i_substate;
          lat_req_n   = i_req_code;
          req_sent_n  = 1'b0;
          resp_rcvd_n = 1'b0;
          resp_sent_n = 1'b0;
          resp_pend_n = early_hit;
          buf_vld_n   = 1'b0;
        end
      end
      ACTIVE: begin
        if (o_tx_valid && i_tx_ready) begin
          if (o_tx_code == lat_req_q) req_sent_n = 1'b1;
          else begin
            resp_sent_n = 1'b1;
            resp_pend_n = 1'b0;
          end
        end
        // rx is applied after tx so a partner REQ in the RESP-accept cycle re-arms the RESP.
        if (rx_hit && i_rx_code == lat_req_q)   resp_pend_n = 1'b1;
        else if (rx_hit && i_rx_code == resp_q) resp_rcvd_n = 1'b1;
        else if (i_rx_valid)                    unexp_n     = 1'b1;
        if (req_sent_n && resp_rcvd_n && resp_sent_n && !resp_pend_n) begin
          fsm_n = DONE;
        end else if (expired) begin
          fsm_n     = ERROR;
          timeout_n = 1'b1;
        end
      end
      default: fsm_n = IDLE;
    endcase
    // Never switch away from an offered but unaccepted message; RESP beats REQ.
    if (fsm_n == ACTIVE) begin
      if (fsm_q == ACTIVE && o_tx_valid && !i_tx_ready) begin
        tx_valid_n = 1'b1;
      end else if (resp_pend_n || !req_sent_n) begin
        tx_valid_n = 1'b1;
        tx_state_n = lat_state_n;
        tx_sub_n   = lat_sub_n;
        tx_code_n  = resp_pend_n ? CODE_W'(resp_of(32'(lat_req_n))) : lat_req_n;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q         <= IDLE;
      lat_state_q   <= '0;
      lat_sub_q     <= '0;
      lat_req_q     <= '0;
      req_sent_q    <= 1'b0;
      resp_rcvd_q   <= 1'b0;
      resp_pend_q   <= 1'b0;
      resp_sent_q   <= 1'b0;
      buf_vld_q     <= 1'b0;
      buf_state_q   <= '0;
      buf_sub_q     <= '0;
      buf_code_q    <= '0;
      o_tx_valid    <= 1'b0;
      o_tx_state    <= '0;
      o_tx_substate <= '0;
      o_tx_code     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_timeout     <= 1'b0;
      o_unexpected  <= 1'b0;
    end else begin
      fsm_q         <= fsm_n;
      lat_state_q   <= lat_state_n;
      lat_sub_q     <= lat_sub_n;
      lat_req_q     <= lat_req_n;
      req_sent_q    <= req_sent_n;
      resp_rcvd_q   <= resp_rcvd_n;
      resp_pend_q   <= resp_pend_n;
      resp_sent_q   <= resp_sent_n;
      buf_vld_q     <= buf_vld_n;
      buf_state_q   <= buf_state_n;
      buf_sub_q     <= buf_sub_n;
      buf_code_q    <= buf_code_n;
      o_tx_valid    <= tx_valid_n;
      o_tx_state    <= tx_state_n;
      o_tx_substate <= tx_sub_n;
      o_tx_code     <= tx_code_n;
      o_busy        <= (fsm_n == ACTIVE);
      o_done        <= (fsm_n == DONE);
      o_timeout     <= timeout_n;
      o_unexpected  <= unexp_n;
    end
  end

endmodule
